// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
package serial_sub_pkg;

   // Default operand/result width
   localparam int unsigned DefaultWidth = 8;

   // Controller states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/fsc_cell.sv
// Combinational full-subtractor cell: z = x - y - bi (one bit), bo = borrow out.
module fsc_cell (
   input  logic bi,
   input  logic x,
   input  logic y,
   output logic z,
   output logic bo
);

   assign z  = x ^ y ^ bi;
   assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: runs one shared full-subtractor cell over WIDTH cycles, LSB first,
// with valid/ready handshakes on operands and result.
module serial_sub_ctrl
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int unsigned     CntW    = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   state_e           state_q;
   logic [WIDTH-1:0] x_sr_q;
   logic [WIDTH-1:0] y_sr_q;
   logic [WIDTH-1:0] d_sr_q;
   logic [WIDTH-1:0] d_shift;
   logic             brw_q;
   logic [CntW-1:0]  cnt_q;
   logic             cell_z;
   logic             cell_b;

   fsc_cell u_cell (
      .bi (brw_q),
      .x  (x_sr_q[0]),
      .y  (y_sr_q[0]),
      .z  (cell_z),
      .bo (cell_b)
   );

   // Result register after this cycle's bit enters the MSB (also valid for WIDTH == 1)
   always_comb begin
      d_shift            = d_sr_q >> 1;
      d_shift[WIDTH-1]   = cell_z;
   end

   // Sequencer: state, datapath shift registers and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         x_sr_q     <= '0;
         y_sr_q     <= '0;
         d_sr_q     <= '0;
         brw_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  x_sr_q   <= x;
                  y_sr_q   <= y;
                  brw_q    <= bin;
                  cnt_q    <= '0;
                  in_ready <= 1'b0;
                  state_q  <= S_RUN;
               end
            end
            S_RUN: begin
               brw_q  <= cell_b;
               x_sr_q <= x_sr_q >> 1;
               y_sr_q <= y_sr_q >> 1;
               d_sr_q <= d_shift;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == CntLast) begin
                  diff       <= d_shift;
                  borrow_out <= cell_b;
                  out_valid  <= 1'b1;
                  state_q    <= S_DONE;
               end
            end
            S_DONE: begin
               // No new acceptance here; operands are taken from IDLE only
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_q   <= S_IDLE;
               end
            end
            default: begin
               state_q   <= S_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
